mem_arbiter: RTL

- Two-requester arbiter sharing the single byte-addressable 16-bit memory port (en/wr/wide/addr/din/dout) between requester A (CPU) and requester B (DMA/video).
- Round-robin with a fixed-priority option; registers the winning command onto the memory port and steers read data back with a valid strobe.
- Sits between the requesters and the memory block; no requester drives memory directly.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared byte-addressable 16-bit memory port.
// Registers the winning command onto the port and returns read data with a per-owner valid strobe.
module mem_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int AW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic          a_wide,
  input  logic [AW-1:0] a_addr,
  input  logic [15:0]   a_din,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [15:0]   a_dout,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic          b_wide,
  input  logic [AW-1:0] b_addr,
  input  logic [15:0]   b_din,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [15:0]   b_dout,
  output logic          mem_en,
  output logic          mem_wr,
  output logic          mem_wide,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout
);

  logic          w_a_elig;
  logic          w_b_elig;
  logic          w_a_win;
  logic          w_b_win;

  logic          r_a_gnt;
  logic          r_b_gnt;
  logic          r_a_tag;
  logic          r_b_tag;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic          r_last_b;
  logic          r_mem_en;
  logic          r_mem_wr;
  logic          r_mem_wide;
  logic [AW-1:0] r_mem_addr;
  logic [15:0]   r_mem_din;

  // A requester that is seeing its grant this cycle is still holding req; mask it out.
  always_comb begin
    w_a_elig = a_req & ~r_a_gnt;
    w_b_elig = b_req & ~r_b_gnt;
    w_a_win  = 1'b0;
    w_b_win  = 1'b0;
    if (w_a_elig && w_b_elig) begin
      if ((FIXED_PRIO != 0) || !r_last_b) begin
        w_b_win = 1'b1;
      end else begin
        w_a_win = 1'b1;
      end
    end else begin
      w_a_win = w_a_elig;
      w_b_win = w_b_elig;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_a_tag    <= 1'b0;
      r_b_tag    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_last_b   <= 1'b1;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_wide <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      r_a_gnt    <= w_a_win;
      r_b_gnt    <= w_b_win;
      // Owner tag rides alongside the granted read; memory data arrives one cycle later.
      r_a_tag    <= w_a_win & ~a_wr;
      r_b_tag    <= w_b_win & ~b_wr;
      r_a_rvalid <= r_a_tag;
      r_b_rvalid <= r_b_tag;
      r_mem_en   <= w_a_win | w_b_win;
      if (w_a_win) begin
        r_mem_wr   <= a_wr;
        r_mem_wide <= a_wide;
        r_mem_addr <= a_addr;
        r_mem_din  <= a_din;
        r_last_b   <= 1'b0;
      end else if (w_b_win) begin
        r_mem_wr   <= b_wr;
        r_mem_wide <= b_wide;
        r_mem_addr <= b_addr;
        r_mem_din  <= b_din;
        r_last_b   <= 1'b1;
      end else begin
        r_mem_wr   <= 1'b0;
      end
    end
  end

  assign a_gnt    = r_a_gnt;
  assign b_gnt    = r_b_gnt;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_dout   = mem_dout;
  assign b_dout   = mem_dout;
  assign mem_en   = r_mem_en;
  assign mem_wr   = r_mem_wr;
  assign mem_wide = r_mem_wide;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

endmodule
